// File: rtl/quadrature_generator_if.sv
// Register-write and quadrature-output bundle for quadrature_generator.
// The slave side is the generator; the master side is whoever programs it.
interface quadrature_generator_if;
  logic        reg_we;
  logic        reg_addr;
  logic [15:0] reg_data;
  logic [15:0] reg_q;
  logic        a;
  logic        b;
  logic        busy;
  logic        done;

  modport slave (
    input  reg_we, reg_addr, reg_data,
    output reg_q, a, b, busy, done
  );

  modport master (
    output reg_we, reg_addr, reg_data,
    input  reg_q, a, b, busy, done
  );
endinterface

// File: rtl/quadrature_generator.sv
// Emits a programmable number of quadrature edges on (a,b), one every PERIOD cycles.
// The sign of the remaining-step register selects direction; reaching zero ends the run.
module quadrature_generator #(
  parameter logic [15:0] PERIOD_RESET = 16'd1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  quadrature_generator_if.slave bus
);

  logic [15:0] remaining_q, remaining_d;
  logic [15:0] period_q, period_d;
  logic [15:0] timer_q, timer_d;
  logic        a_q, a_d;
  logic        b_q, b_d;
  logic        done_q, done_d;

  logic        wr_steps_s;
  logic        wr_period_s;
  logic        running_s;
  logic [15:0] reload_s;

  assign wr_steps_s  = bus.reg_we && (bus.reg_addr == 1'b0);
  assign wr_period_s = bus.reg_we && (bus.reg_addr == 1'b1);
  assign running_s   = (remaining_q != 16'h0000);
  // A period of zero behaves as one clock per edge.
  assign reload_s    = (period_q == 16'd0) ? 16'd0 : (period_q - 16'd1);

  // State register: async reset returns phase to 00 and aborts any run without done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= 16'h0000;
      period_q    <= PERIOD_RESET;
      timer_q     <= 16'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      a_q         <= a_d;
      b_q         <= b_d;
      done_q      <= done_d;
    end
  end

  // Next state: a step-count write wins over a coinciding edge event.
  always_comb begin
    remaining_d = remaining_q;
    timer_d     = timer_q;
    a_d         = a_q;
    b_d         = b_q;
    done_d      = 1'b0;
    if (wr_steps_s) begin
      remaining_d = bus.reg_data;
      timer_d     = reload_s;
    end else if (running_s) begin
      if (timer_q == 16'd0) begin
        timer_d = reload_s;
        done_d  = (remaining_q == 16'h0001) || (remaining_q == 16'hFFFF);
        // Forward rotates (a,b) -> (~b,a); reverse rotates (a,b) -> (b,~a).
        if (remaining_q[15] == 1'b0) begin
          a_d         = ~b_q;
          b_d         = a_q;
          remaining_d = remaining_q - 16'h0001;
        end else begin
          a_d         = b_q;
          b_d         = ~a_q;
          remaining_d = remaining_q + 16'h0001;
        end
      end else begin
        timer_d = timer_q - 16'd1;
      end
    end else begin
      timer_d = timer_q;
    end
    if (wr_period_s) begin
      period_d = bus.reg_data;
    end else begin
      period_d = period_q;
    end
  end

  // Outputs: phases and done come straight from flops; busy and readback from registers.
  always_comb begin
    bus.a    = a_q;
    bus.b    = b_q;
    bus.done = done_q;
    bus.busy = running_s;
    if (bus.reg_addr == 1'b1) begin
      bus.reg_q = period_q;
    end else begin
      bus.reg_q = remaining_q;
    end
  end

endmodule

// File: tb/tb_quadrature_generator.sv
// Randomized and directed bench for quadrature_generator against a phase-index
// and edge-countdown reference model.
module tb_quadrature_generator;
  logic clk;
  logic rst_n;
  quadrature_generator_if bus ();

  quadrature_generator #(.PERIOD_RESET(16'd1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: run length, period, cycles left until the next edge, phase index.
  int m_rem;
  int m_per;
  int m_cnt;
  int m_ph;
  bit m_done;

  function automatic logic [1:0] ab_of(input int ph);
    logic [1:0] tbl [4];
    tbl[0] = 2'b00; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01;
    return tbl[ph];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_per = 1000; m_cnt = 0; m_ph = 0; m_done = 0;
  endtask

  task automatic cmp_all();
    logic [1:0] e;
    e = ab_of(m_ph);
    chk("a", 32'(bus.a), 32'(e[1]));
    chk("b", 32'(bus.b), 32'(e[0]));
    chk("busy", 32'(bus.busy), 32'(m_rem != 0));
    chk("done", 32'(bus.done), 32'(m_done));
    if (bus.reg_addr) chk("rd_period", 32'(bus.reg_q), 32'(m_per[15:0]));
    else              chk("rd_steps", 32'(bus.reg_q), 32'(m_rem[15:0]));
  endtask

  // One clock: apply inputs, advance the model by the rules, compare after the edge.
  task automatic cycle(input logic we, input logic addr, input logic [15:0] data);
    int p;
    p = (m_per == 0) ? 1 : m_per;
    bus.reg_we = we; bus.reg_addr = addr; bus.reg_data = data;
    m_done = 0;
    if (we && !addr) begin
      m_rem = int'($signed(data));
      m_cnt = p;
    end else if (m_rem != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (m_rem > 0) begin m_ph = (m_ph + 1) % 4; m_rem--; end
        else           begin m_ph = (m_ph + 3) % 4; m_rem++; end
        m_cnt  = p;
        m_done = (m_rem == 0);
      end
    end
    if (we && addr) m_per = int'(data);
    @(posedge clk);
    #1;
    bus.reg_we = 1'b0;
    cmp_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, bus.reg_addr, 16'h0000);
  endtask

  int          dones;
  int          toggles;
  logic [1:0]  prev_ab;
  logic [15:0] d;

  initial begin
    bus.reg_we = 1'b0; bus.reg_addr = 1'b1; bus.reg_data = 16'h0000;
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_a", 32'(bus.a), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_period", 32'(bus.reg_q), 32'd1000);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(5);

    // Forward run, period 4, +3 steps.
    cycle(1'b1, 1'b1, 16'd4);
    bus.reg_addr = 1'b0;
    cycle(1'b1, 1'b0, 16'd3);
    idle(4);  chk("fwd_t4",  32'({bus.a, bus.b}), 32'b10);
    idle(4);  chk("fwd_t8",  32'({bus.a, bus.b}), 32'b11);
    idle(4);  chk("fwd_t12", 32'({bus.a, bus.b}), 32'b01);
    chk("fwd_done", 32'(bus.done), 32'd1);
    idle(1);  chk("fwd_done_one", 32'(bus.done), 32'd0);
    chk("fwd_busy_low", 32'(bus.busy), 32'd0);

    // Bring phase back to 00, then reverse run, period 2, -2 steps.
    cycle(1'b1, 1'b0, 16'd1);
    idle(5);
    cycle(1'b1, 1'b1, 16'd2);
    bus.reg_addr = 1'b0;
    cycle(1'b1, 1'b0, 16'hFFFE);
    idle(2); chk("rev_t2", 32'({bus.a, bus.b}), 32'b01);
    chk("rev_rd1", 32'(bus.reg_q), 32'hFFFF);
    idle(2); chk("rev_t4", 32'({bus.a, bus.b}), 32'b11);
    chk("rev_rd0", 32'(bus.reg_q), 32'h0000);

    // Abort after two edges with period 3.
    cycle(1'b1, 1'b1, 16'd3);
    bus.reg_addr = 1'b0;
    cycle(1'b1, 1'b0, 16'd100);
    idle(6);
    cycle(1'b1, 1'b0, 16'h0000);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    idle(8);

    // Period 0: one edge per clock, exactly one phase toggles each cycle.
    cycle(1'b1, 1'b1, 16'd0);
    bus.reg_addr = 1'b0;
    cycle(1'b1, 1'b0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      prev_ab = {bus.a, bus.b};
      idle(1);
      chk("p0_onehot", 32'($countones(prev_ab ^ {bus.a, bus.b})), 32'd1);
    end
    idle(3);

    // Collision: -5 written on the very clock a forward edge is due.
    cycle(1'b1, 1'b1, 16'd3);
    bus.reg_addr = 1'b0;
    cycle(1'b1, 1'b0, 16'd10);
    idle(5);
    prev_ab = {bus.a, bus.b};
    cycle(1'b1, 1'b0, 16'hFFFB);
    chk("coll_hold", 32'({bus.a, bus.b}), 32'(prev_ab));
    idle(3);
    idle(20);

    // Mid-run asynchronous reset while a is high.
    cycle(1'b1, 1'b1, 16'd1);
    bus.reg_addr = 1'b0;
    cycle(1'b1, 1'b0, 16'd50);
    for (int i = 0; i < 8 && !bus.a; i++) idle(1);
    chk("pre_rst_a", 32'(bus.a), 32'd1);
    bus.reg_addr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_a", 32'(bus.a), 32'd0);
    chk("mrst_b", 32'(bus.b), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_period", 32'(bus.reg_q), 32'd1000);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    idle(4);

    // Randomized writes of small step counts and periods.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        d = 16'(int'($urandom_range(0, 12)) - 6);
        cycle(1'b1, 1'b0, d);
      end else if ($urandom_range(0, 29) == 0) begin
        d = 16'($urandom_range(0, 3));
        cycle(1'b1, 1'b1, d);
      end else begin
        bus.reg_addr = 1'($urandom_range(0, 1));
        idle(1);
      end
    end
    cycle(1'b1, 1'b0, 16'h0000);

    // Most negative count: 32768 reverse edges at one per clock.
    cycle(1'b1, 1'b1, 16'd0);
    bus.reg_addr = 1'b0;
    cycle(1'b1, 1'b0, 16'h8000);
    dones = 0; toggles = 0;
    for (int i = 0; i < 33000 && bus.busy; i++) begin
      prev_ab = {bus.a, bus.b};
      idle(1);
      if (prev_ab != {bus.a, bus.b}) toggles++;
      if (bus.done) dones++;
    end
    idle(1);
    if (bus.done) dones++;
    chk("min_edges", 32'(toggles), 32'd32768);
    chk("min_dones", 32'(dones), 32'd1);
    chk("min_idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
